// File: rtl/sched_pkg.sv
// sched_pkg: shared types, port encodings and the round-robin helper for rr_xbar_scheduler.
// Latency: n/a (types and a pure function only).
// Backpressure: n/a.
package sched_pkg;

  // Select / destination encoding: 0 = none, 1..3 = port number.
  typedef logic [1:0] port_sel_t;

  localparam port_sel_t PORT_NONE = 2'd0;
  localparam port_sel_t PORT_1    = 2'd1;
  localparam port_sel_t PORT_2    = 2'd2;
  localparam port_sel_t PORT_3    = 2'd3;

  // A header whose dest field is 00 goes to the drop sink.
  localparam port_sel_t DEST_DROP = 2'b00;

  localparam int HDR_W = 8;
  localparam int LEN_W = HDR_W - 2;

  // Header word layout for the default 8-bit FIFO width.
  typedef struct packed {
    logic [LEN_W-1:0] len;
    port_sel_t        dest;
  } hdr_t;

  // Round-robin pick: scan last+1, last+2, last+3 (1-based, wrapping 3 -> 1)
  // and return the first requesting input, or PORT_NONE if none requests.
  function automatic port_sel_t rr_next(input port_sel_t last, input logic [2:0] req);
    port_sel_t p;
    port_sel_t res;
    p   = last;
    res = PORT_NONE;
    for (int k = 0; k < 3; k++) begin
      p = ((p == PORT_3) || (p == PORT_NONE)) ? PORT_1 : port_sel_t'(p + 2'd1);
      if ((res == PORT_NONE) && req[p - 2'd1]) res = p;
    end
    return res;
  endfunction

endpackage

// File: rtl/sched_out_ctrl.sv
// sched_out_ctrl: per-output packet grant FSM (IDLE/BUSY), RR pointer, word counter, sel register.
// Latency: candidate seen at t -> sel registered at t+1; sel clears the cycle after the final pop.
// Backpressure: counter only moves on the granted input's rdreq, so an empty FIFO stalls the packet.
//
// Ports:
//   clk, reset_n  clock, async active-low reset
//   cand[2:0]     FREE, non-empty inputs whose header targets this output
//   len[2:0]      header len field of each input's head word
//   rdreq[2:0]    pop strobes of all inputs (this output watches only its granted one)
//   sel           granted input (0 = none)
//   done          final word of the current packet is being popped this cycle
module sched_out_ctrl
  import sched_pkg::*;
#(
  parameter int LEN_W = 6
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [2:0]            cand,
  input  logic [2:0][LEN_W-1:0] len,
  input  logic [2:0]            rdreq,
  output port_sel_t             sel,
  output logic                  done
);

  localparam int CNT_W = LEN_W + 1;  // len+1 words, up to 64

  typedef enum logic {ST_IDLE, ST_BUSY} state_t;

  state_t           state;
  port_sel_t        last;
  port_sel_t        pick;
  logic [CNT_W-1:0] cnt;
  logic [LEN_W-1:0] pick_len;
  logic             pop;

  always_comb begin
    pick     = rr_next(last, cand);
    pick_len = '0;
    pop      = 1'b0;
    case (pick)
      PORT_1:  pick_len = len[0];
      PORT_2:  pick_len = len[1];
      PORT_3:  pick_len = len[2];
      default: pick_len = '0;
    endcase
    case (sel)
      PORT_1:  pop = rdreq[0];
      PORT_2:  pop = rdreq[1];
      PORT_3:  pop = rdreq[2];
      default: pop = 1'b0;
    endcase
    done = (state == ST_BUSY) && pop && (cnt == CNT_W'(1));
  end

  // Completion drops straight back to IDLE without looking at candidates,
  // which gives the mandatory one-cycle gap between packets on this output.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
      sel   <= PORT_NONE;
      last  <= PORT_3;
      cnt   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cand != 3'b000) begin
            state <= ST_BUSY;
            sel   <= pick;
            last  <= pick;
            cnt   <= CNT_W'(pick_len) + CNT_W'(1);
          end
        end
        ST_BUSY: begin
          if (pop) begin
            if (cnt == CNT_W'(1)) begin
              state <= ST_IDLE;
              sel   <= PORT_NONE;
              cnt   <= '0;
            end else begin
              cnt <= cnt - CNT_W'(1);
            end
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/rr_xbar_scheduler.sv
// rr_xbar_scheduler: packet-granular 3x3 crossbar scheduler with per-output round-robin and a drop sink.
// Latency: header visible at t -> sel/lock at t+1 -> header popped at t+1, then one word per cycle.
// Backpressure: rdreq_i = LOCKED(i) && !empty_i; an empty FIFO mid-packet stalls with lock/sel/counter held.
//
// Ports:
//   clk, reset_n        clock, async active-low reset (input FIFOs are flushed by the same reset)
//   data1..3, empty1..3 show-ahead head word / empty flag of input FIFO 1..3
//   sel1..3             source for output 1..3 (0 = none, 1..3 = input)
//   rdreq1..3           pop input FIFO 1..3 this cycle
//   pkt_cnt1..3         packets completed per output    (SCHED_STATS_EN only)
//   drop_cnt            packets sent to the drop sink   (SCHED_STATS_EN only)
// Optional feature macro: SCHED_STATS_EN adds the statistics counters and the STAT_W parameter.
module rr_xbar_scheduler
  import sched_pkg::*;
#(
  parameter int DATA_W = 8
`ifdef SCHED_STATS_EN
  ,
  parameter int STAT_W = 16
`endif
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] data1,
  input  logic [DATA_W-1:0] data2,
  input  logic [DATA_W-1:0] data3,
  input  logic              empty1,
  input  logic              empty2,
  input  logic              empty3,
  output logic [1:0]        sel1,
  output logic [1:0]        sel2,
  output logic [1:0]        sel3,
  output logic              rdreq1,
  output logic              rdreq2,
  output logic              rdreq3
`ifdef SCHED_STATS_EN
  ,
  output logic [STAT_W-1:0] pkt_cnt1,
  output logic [STAT_W-1:0] pkt_cnt2,
  output logic [STAT_W-1:0] pkt_cnt3,
  output logic [STAT_W-1:0] drop_cnt
`endif
);

  localparam int HLEN_W = DATA_W - 2;
  localparam int CNT_W  = HLEN_W + 1;

  logic [DATA_W-1:0]         data_a [3];
  logic [2:0]                empty_v;
  logic [2:0][HLEN_W-1:0]    len_v;
  port_sel_t                 dest_a [3];
  port_sel_t                 sel_a  [3];
  logic [2:0]                cand   [3];
  logic [2:0]                done_v;

  // Input lock table: an input is locked to an output when some sel names it,
  // or locked to the drop sink when its drop_lock bit is set.
  logic [2:0]                out_lock;
  logic [2:0]                drop_lock;
  logic [CNT_W-1:0]          drop_wcnt [3];
  logic [2:0]                in_free;
  logic [2:0]                rdreq_v;
  logic [2:0]                drop_start;
  logic [2:0]                drop_done;

  assign data_a[0] = data1;
  assign data_a[1] = data2;
  assign data_a[2] = data3;
  assign empty_v   = {empty3, empty2, empty1};

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      len_v[i]  = data_a[i][DATA_W-1:2];
      dest_a[i] = data_a[i][1:0];
    end
  end

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      out_lock[i] = 1'b0;
      for (int o = 0; o < 3; o++) begin
        if (sel_a[o] == port_sel_t'(i + 1)) out_lock[i] = 1'b1;
      end
      in_free[i]    = !out_lock[i] && !drop_lock[i];
      rdreq_v[i]    = (out_lock[i] || drop_lock[i]) && !empty_v[i];
      drop_start[i] = in_free[i] && !empty_v[i] && (dest_a[i] == DEST_DROP);
      drop_done[i]  = drop_lock[i] && rdreq_v[i] && (drop_wcnt[i] == CNT_W'(1));
    end
    // Destinations are disjoint, so a FREE input is a candidate for at most one output.
    for (int o = 0; o < 3; o++) begin
      for (int i = 0; i < 3; i++) begin
        cand[o][i] = in_free[i] && !empty_v[i] && (dest_a[i] == port_sel_t'(o + 1));
      end
    end
  end

  // Drop sink: each input has its own drop lock, so drops never wait on anything.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      drop_lock <= '0;
      for (int i = 0; i < 3; i++) drop_wcnt[i] <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (drop_start[i]) begin
          drop_lock[i] <= 1'b1;
          drop_wcnt[i] <= CNT_W'(len_v[i]) + CNT_W'(1);
        end else if (drop_lock[i] && rdreq_v[i]) begin
          if (drop_wcnt[i] == CNT_W'(1)) begin
            drop_lock[i] <= 1'b0;
            drop_wcnt[i] <= '0;
          end else begin
            drop_wcnt[i] <= drop_wcnt[i] - CNT_W'(1);
          end
        end
      end
    end
  end

  for (genvar o = 0; o < 3; o++) begin : g_out
    sched_out_ctrl #(
      .LEN_W (HLEN_W)
    ) u_out_ctrl (
      .clk     (clk),
      .reset_n (reset_n),
      .cand    (cand[o]),
      .len     (len_v),
      .rdreq   (rdreq_v),
      .sel     (sel_a[o]),
      .done    (done_v[o])
    );
  end

  assign sel1   = sel_a[0];
  assign sel2   = sel_a[1];
  assign sel3   = sel_a[2];
  assign rdreq1 = rdreq_v[0];
  assign rdreq2 = rdreq_v[1];
  assign rdreq3 = rdreq_v[2];

`ifdef SCHED_STATS_EN
  logic [STAT_W-1:0] pkt_cnt_r [3];
  logic [STAT_W-1:0] drop_cnt_r;
  logic [1:0]        drops_now;

  // Several inputs can finish a drop in the same cycle.
  assign drops_now = 2'(drop_done[0]) + 2'(drop_done[1]) + 2'(drop_done[2]);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int o = 0; o < 3; o++) pkt_cnt_r[o] <= '0;
      drop_cnt_r <= '0;
    end else begin
      for (int o = 0; o < 3; o++) begin
        if (done_v[o]) pkt_cnt_r[o] <= pkt_cnt_r[o] + STAT_W'(1);
      end
      drop_cnt_r <= drop_cnt_r + STAT_W'(drops_now);
    end
  end

  assign pkt_cnt1 = pkt_cnt_r[0];
  assign pkt_cnt2 = pkt_cnt_r[1];
  assign pkt_cnt3 = pkt_cnt_r[2];
  assign drop_cnt = drop_cnt_r;
`endif

  // No two outputs may select the same input.
  a_sel_unique: assert property (@(posedge clk) disable iff (!reset_n)
    !(((sel_a[0] != PORT_NONE) && (sel_a[0] == sel_a[1])) ||
      ((sel_a[0] != PORT_NONE) && (sel_a[0] == sel_a[2])) ||
      ((sel_a[1] != PORT_NONE) && (sel_a[1] == sel_a[2]))));

  // An input is never held by an output and the drop sink at once.
  a_single_lock: assert property (@(posedge clk) disable iff (!reset_n)
    (out_lock & drop_lock) == 3'b000);

  // Packet completions only happen on an active lock.
  a_done_locked: assert property (@(posedge clk) disable iff (!reset_n)
    ((done_v & ~{sel_a[2] != PORT_NONE, sel_a[1] != PORT_NONE, sel_a[0] != PORT_NONE}) == 3'b000) &&
    ((drop_done & ~drop_lock) == 3'b000));

endmodule

// File: tb/tb_rr_xbar_scheduler.sv
`timescale 1ns/1ps
module tb_rr_xbar_scheduler;
  import sched_pkg::*;

  logic       clk;
  logic       reset_n;
  logic [7:0] data1, data2, data3;
  logic       empty1, empty2, empty3;
  logic [1:0] sel1, sel2, sel3;
  logic       rdreq1, rdreq2, rdreq3;
`ifdef SCHED_STATS_EN
  logic [3:0] pkt_cnt1, pkt_cnt2, pkt_cnt3, drop_cnt;
`endif

  rr_xbar_scheduler #(
    .DATA_W (8)
`ifdef SCHED_STATS_EN
    ,
    .STAT_W (4)
`endif
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .data1    (data1),
    .data2    (data2),
    .data3    (data3),
    .empty1   (empty1),
    .empty2   (empty2),
    .empty3   (empty3),
    .sel1     (sel1),
    .sel2     (sel2),
    .sel3     (sel3),
    .rdreq1   (rdreq1),
    .rdreq2   (rdreq2),
    .rdreq3   (rdreq3)
`ifdef SCHED_STATS_EN
    ,
    .pkt_cnt1 (pkt_cnt1),
    .pkt_cnt2 (pkt_cnt2),
    .pkt_cnt3 (pkt_cnt3),
    .drop_cnt (drop_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_errors = 0;
  logic [7:0] q1 [$];
  logic [7:0] q2 [$];
  logic [7:0] q3 [$];
  logic [2:0] rd_s;
  int         pops [3];
  int         bad_pops = 0;
  logic       stall2;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Show-ahead FIFO model outputs; stall2 forces input 2 to look empty.
  task automatic drive();
    data1  = (q1.size() != 0) ? q1[0] : 8'h00;
    data2  = (q2.size() != 0) ? q2[0] : 8'h00;
    data3  = (q3.size() != 0) ? q3[0] : 8'h00;
    empty1 = (q1.size() == 0);
    empty2 = (q2.size() == 0) || stall2;
    empty3 = (q3.size() == 0);
  endtask

  task automatic push_pkt(input int port, input logic [7:0] hdr);
    hdr_t       h;
    logic [7:0] w;
    h = hdr_t'(hdr);
    for (int k = 0; k <= int'(h.len); k++) begin
      w = (k == 0) ? hdr : 8'(8'hC0 + k);
      case (port)
        1:       q1.push_back(w);
        2:       q2.push_back(w);
        default: q3.push_back(w);
      endcase
    end
  endtask

  task automatic clr_pops();
    for (int i = 0; i < 3; i++) pops[i] = 0;
  endtask

  function automatic int sel_ok();
    return ((sel1 != 0 && sel1 == sel2) || (sel1 != 0 && sel1 == sel3) ||
            (sel2 != 0 && sel2 == sel3)) ? 0 : 1;
  endfunction

  // One clock: sample rdreq just before the edge, pop the model FIFOs after it,
  // then stop on the falling edge where outputs are compared.
  task automatic step();
    #1;
    rd_s = {rdreq3, rdreq2, rdreq1};
    @(posedge clk);
    #1;
    if (rd_s[0]) begin if (q1.size() == 0) bad_pops++; else begin void'(q1.pop_front()); pops[0]++; end end
    if (rd_s[1]) begin if (q2.size() == 0) bad_pops++; else begin void'(q2.pop_front()); pops[1]++; end end
    if (rd_s[2]) begin if (q3.size() == 0) bad_pops++; else begin void'(q3.pop_front()); pops[2]++; end end
    drive();
    @(negedge clk);
    check("sel_unique", sel_ok(), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_sel2 [12];
    int exp_rd   [12];
    int cyc;
    exp_sel2 = '{1, 1, 1, 0, 2, 2, 2, 0, 3, 3, 3, 0};
    exp_rd   = '{1, 1, 1, 0, 2, 2, 2, 0, 4, 4, 4, 0};

    reset_n = 1'b1;
    stall2  = 1'b0;
    rd_s    = '0;
    clr_pops();
    drive();
    #3 reset_n = 1'b0;
    #1;
    check("rst_sel", int'({sel3, sel2, sel1}), 0);
    check("rst_rdreq", int'({rdreq3, rdreq2, rdreq1}), 0);
    @(negedge clk);
    reset_n = 1'b1;

    // 1a: reset asserted in the middle of a packet
    push_pkt(1, 8'h15);
    drive();
    step();
    check("t1_grant_sel1", int'(sel1), 1);
    step();
    step();
    check("t1_mid_sel1", int'(sel1), 1);
    check("t1_mid_rdreq1", int'(rdreq1), 1);
    #2 reset_n = 1'b0;
    #1;
    check("t1_async_sel", int'({sel3, sel2, sel1}), 0);
    check("t1_async_rdreq", int'({rdreq3, rdreq2, rdreq1}), 0);
    q1.delete(); q2.delete(); q3.delete();
    drive();
    @(negedge clk);
    reset_n = 1'b1;

    // 1b: header 8'h05 after reset release
    clr_pops();
    push_pkt(1, 8'h05);
    drive();
    #1;
    check("t1b_pre_sel1", int'(sel1), 0);
    step();
    check("t1b_sel1", int'(sel1), 1);
    check("t1b_rdreq1", int'(rdreq1), 1);
    step();
    check("t1b_sel1_hold", int'(sel1), 1);
    step();
    check("t1b_sel1_end", int'(sel1), 0);
    check("t1b_pops1", pops[0], 2);

    // 2: three inputs contend for output 2 with header 8'h0A
    clr_pops();
    push_pkt(1, 8'h0A);
    push_pkt(2, 8'h0A);
    push_pkt(3, 8'h0A);
    drive();
    for (int c = 0; c < 12; c++) begin
      step();
      check("t2_sel2", int'(sel2), exp_sel2[c]);
      check("t2_rdreq", int'({rdreq3, rdreq2, rdreq1}), exp_rd[c]);
      check("t2_other_sel", int'({sel3, sel1}), 0);
    end
    check("t2_pops", pops[0] * 100 + pops[1] * 10 + pops[2], 333);

    // 3: in1->out3, in2->out1, in3->out2 in the same cycle
    clr_pops();
    push_pkt(1, 8'h0B);
    push_pkt(2, 8'h09);
    push_pkt(3, 8'h0A);
    drive();
    step();
    check("t3_sel1", int'(sel1), 2);
    check("t3_sel2", int'(sel2), 3);
    check("t3_sel3", int'(sel3), 1);
    for (int c = 0; c < 3; c++) begin
      check("t3_rdreq", int'({rdreq3, rdreq2, rdreq1}), 7);
      step();
    end
    check("t3_sel_end", int'({sel3, sel2, sel1}), 0);
    check("t3_pops", pops[0] * 100 + pops[1] * 10 + pops[2], 333);

    // 4: input 2 runs dry for 4 cycles in the middle of a len-5 packet
    clr_pops();
    push_pkt(2, 8'h15);
    drive();
    step();
    check("t4_sel1", int'(sel1), 2);
    step();
    step();
    check("t4_pops_before", pops[1], 2);
    stall2 = 1'b1;
    drive();
    for (int c = 0; c < 4; c++) begin
      step();
      check("t4_stall_rdreq2", int'(rdreq2), 0);
      check("t4_stall_sel1", int'(sel1), 2);
    end
    check("t4_pops_stall", pops[1], 2);
    stall2 = 1'b0;
    drive();
    step();
    step();
    step();
    check("t4_sel1_last", int'(sel1), 2);
    step();
    check("t4_sel1_end", int'(sel1), 0);
    check("t4_pops2", pops[1], 6);
    check("t4_q2_empty", q2.size(), 0);

    // 5: header 8'h0C (dest 00, len 3) on input 3 goes to the drop sink
    clr_pops();
    push_pkt(3, 8'h0C);
    drive();
    step();
    check("t5_rdreq3", int'(rdreq3), 1);
    check("t5_sel", int'({sel3, sel2, sel1}), 0);
    for (int c = 0; c < 4; c++) begin
      step();
      check("t5_sel_drop", int'({sel3, sel2, sel1}), 0);
    end
    check("t5_pops3", pops[2], 4);
    check("t5_rdreq3_end", int'(rdreq3), 0);

`ifdef SCHED_STATS_EN
    check("st_pkt_cnt1", int'(pkt_cnt1), 3);
    check("st_pkt_cnt2", int'(pkt_cnt2), 4);
    check("st_pkt_cnt3", int'(pkt_cnt3), 1);
    check("st_drop_cnt", int'(drop_cnt), 1);

    // 6: 17 single-word packets to output 1 wrap a 4-bit counter to 1
    #2 reset_n = 1'b0;
    #1;
    check("t6_rst_pkt_cnt1", int'(pkt_cnt1), 0);
    check("t6_rst_drop_cnt", int'(drop_cnt), 0);
    @(negedge clk);
    reset_n = 1'b1;
    clr_pops();
    for (int p = 0; p < 17; p++) push_pkt(1, 8'h01);
    drive();
    cyc = 0;
    while (((q1.size() != 0) || (sel1 != 0)) && (cyc < 200)) begin
      step();
      cyc++;
    end
    check("t6_no_timeout", (cyc < 200) ? 1 : 0, 1);
    check("t6_cycles", cyc, 34);
    check("t6_pops1", pops[0], 17);
    check("t6_pkt_cnt1_wrap", int'(pkt_cnt1), 1);
`endif

    check("no_empty_pops", bad_pops, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
